rnd_dispatch: RTL and testbench
===============================

RND_DISPATCH -- requirements
Module: rnd_dispatch

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WORDS, fixed at 16, number of 32-bit words per block.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port blk_in, input, 512 bits: shuffled PRNG block; word k = blk_in[32k+31:32k].
REQ-006 SHALL have port blk_load, output, 1 bit: one-cycle pulse marking the cycle blk_in is captured.
REQ-007 SHALL have port req, input, NREQ bits: level request per requester, held until granted.
REQ-008 SHALL have port gnt, output, NREQ bits: registered one-hot grant, at most one bit set.
REQ-009 SHALL have port data, output, 32 bits: the dispensed word, valid while valid=1.
REQ-010 SHALL have port valid, output, 1 bit: high exactly in cycles where gnt is non-zero.
REQ-011 SHALL have port words_left, output, 5 bits: unread words remaining in the buffer (0..16).

Function
REQ-012 SHALL implement the states EMPTY, LOAD and SERVE.
REQ-013 EMPTY SHALL go to LOAD unconditionally on the next clock.
REQ-014 LOAD SHALL capture all 512 bits of blk_in, pulse blk_load, set the read index to 0 and words_left to 16, then go to SERVE.
REQ-015 In SERVE, a cycle with req non-zero SHALL pick one requester round-robin, starting at the index after the last granted one.
REQ-016 The grant from REQ-015 SHALL appear on the next edge as gnt one-hot, valid=1 and data=buffer[index]; the index then increments and words_left decrements.
REQ-017 Latency from req sampled high to gnt/valid/data SHALL be exactly one cycle when in SERVE.
REQ-018 A requester's req seen high in the same cycle as its gnt SHALL be treated as a new request.
REQ-019 A requester that drops req before being granted SHALL NOT be granted.
REQ-020 When word 15 is granted, the state SHALL go to LOAD (words_left=0 for that cycle), giving 16 words per 17 cycles under full demand.
REQ-021 No grant SHALL be issued in EMPTY or LOAD; req in those states is held off, not lost.
REQ-022 In a cycle with no grant, gnt SHALL be 0, valid 0 and data 0.
REQ-023 The round-robin pointer SHALL be updated only on a grant.

Reset
REQ-024 On resn low, the state SHALL go to EMPTY asynchronously.
REQ-025 On resn low, gnt, valid, data, blk_load and words_left SHALL be 0, and the round-robin pointer SHALL give requester 0 first priority.
REQ-026 Reset mid-block SHALL discard buffered words; the first block after reset SHALL be captured freshly.

Configuration
REQ-027 With RND_DISPATCH_STATS_EN defined, the block SHALL add output grant_total[31:0], counting grants (wrapping at 2^32) and reset to 0.
REQ-028 Without RND_DISPATCH_STATS_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 A shared package rnd_pkg SHALL hold the state enum, WORD_W=32 and WORDS=16.
REQ-030 The round-robin one-hot picker SHALL be a sub-module rr_pick (inputs req and pointer; output one-hot).

Verification
REQ-031 Reset release, blk_in word k = 32'h1000_0000+k, req=4'b0001 held -> blk_load at cycle 2, then data 10000000..1000000F on consecutive cycles, reload, repeat.
REQ-032 req=4'b1111 held -> gnt sequence 0001,0010,0100,1000,0001,... with no requester granted twice before all others are granted.
REQ-033 req=4'b0100 pulsed for one cycle while in LOAD -> no grant; req held into SERVE -> gnt=0100 one cycle later.
REQ-034 resn pulsed low after 7 words -> outputs 0 immediately; after release, a new capture occurs and word 0 of the new blk_in is dispensed first, to requester 0 if requested.
REQ-035 Full demand for 1000 cycles -> exactly 16 valid words per 17-cycle window, one blk_load per window, and valid equals (gnt != 0) every cycle.
REQ-036 With RND_DISPATCH_STATS_EN defined, 40 grants -> grant_total=40; after reset, grant_total=0.

Source files
------------

// File: rtl/rnd_pkg.sv
// ============================================================================
// rnd_pkg
// Shared types and constants for the random-word dispatcher.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rnd_pkg;

  // Width of one dispensed word and number of words per PRNG block.
  localparam int WORD_W = 32;
  localparam int WORDS  = 16;

  // Dispatcher control states.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick
// Round-robin one-hot picker: returns the first set request bit found when
// scanning upward from index ptr, wrapping at NREQ.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import rnd_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;
  int               w_sum;

  // Scan from the pointer position, claim the first active request.
  always_comb begin
    onehot  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = int'(ptr) + i;
      if (w_sum >= NREQ) begin
        w_sum = w_sum - NREQ;
      end
      w_idx = PTR_W'(w_sum);
      if (!w_found && req[w_idx]) begin
        onehot[w_idx] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rnd_dispatch.sv
// ============================================================================
// rnd_dispatch
// Captures a 16-word shuffled PRNG block and dispenses one word per cycle to
// round-robin-arbitrated requesters with one cycle of grant latency; reloads
// a fresh block after the last word is handed out.
// Optional feature macro: RND_DISPATCH_STATS_EN adds the grant_total counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rnd_dispatch #(
  parameter int NREQ  = 4,
  parameter int WORDS = rnd_pkg::WORDS
) (
  input  logic                            clk,
  input  logic                            resn,
  input  logic [WORDS*rnd_pkg::WORD_W-1:0] blk_in,
  output logic                            blk_load,
  input  logic [NREQ-1:0]                 req,
  output logic [NREQ-1:0]                 gnt,
  output logic [rnd_pkg::WORD_W-1:0]      data,
  output logic                            valid,
  output logic [4:0]                      words_left
`ifdef RND_DISPATCH_STATS_EN
  ,
  output logic [31:0]                     grant_total
`endif
);

  import rnd_pkg::*;

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic                          w_take;
  logic [NREQ-1:0]               w_pick;
  logic [PTR_W-1:0]              w_pick_idx;
  logic [PTR_W-1:0]              w_ptr_nxt;
  logic [PTR_W-1:0]              r_ptr;
  logic [3:0]                    r_idx;
  logic [4:0]                    r_left;
  logic [NREQ-1:0]               r_gnt;
  logic [WORD_W-1:0]             r_data;
  logic                          r_valid;
  logic [WORDS-1:0][WORD_W-1:0]  r_buf;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .onehot (w_pick)
  );

  // State register; reset drops straight back to EMPTY and abandons the block.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and grant decision; grants are only taken while serving.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      ST_EMPTY: w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_SERVE;
      ST_SERVE: begin
        if (|req) begin
          w_take = 1'b1;
          if (r_idx == 4'(WORDS - 1)) begin
            w_state_nxt = ST_LOAD;
          end
        end
      end
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Convert the one-hot pick to an index and advance the pointer past it.
  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick[i]) begin
        w_pick_idx = PTR_W'(i);
      end
    end
    w_ptr_nxt = (w_pick_idx == PTR_W'(NREQ - 1)) ? '0 : w_pick_idx + 1'b1;
  end

  // Registered grant outputs, read index, word count and round-robin pointer.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_left  <= '0;
      r_ptr   <= '0;
    end else begin
      r_gnt   <= w_take ? w_pick : '0;
      r_valid <= w_take;
      r_data  <= w_take ? r_buf[r_idx] : '0;
      if (r_state == ST_LOAD) begin
        r_idx  <= '0;
        r_left <= 5'(WORDS);
      end else if (w_take) begin
        r_idx  <= r_idx + 4'd1;
        r_left <= r_left - 5'd1;
        r_ptr  <= w_ptr_nxt;
      end
    end
  end

  // Block buffer is refilled on every LOAD, so it needs no reset.
  always_ff @(posedge clk) begin
    if (r_state == ST_LOAD) begin
      r_buf <= blk_in;
    end
  end

`ifdef RND_DISPATCH_STATS_EN
  logic [31:0] r_grant_total;

  // Free-running grant counter, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      r_grant_total <= '0;
    end else if (w_take) begin
      r_grant_total <= r_grant_total + 32'd1;
    end
  end

  assign grant_total = r_grant_total;
`endif

  assign blk_load   = (r_state == ST_LOAD);
  assign gnt        = r_gnt;
  assign valid      = r_valid;
  assign data       = r_data;
  assign words_left = r_left;

endmodule

`default_nettype wire

// File: tb/tb_rnd_dispatch.sv
// ============================================================================
// tb_rnd_dispatch
// Directed self-checking bench for rnd_dispatch (NREQ = 4).
// Optional feature macro: RND_DISPATCH_STATS_EN enables grant_total checks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rnd_dispatch;

  logic         clk;
  logic         resn;
  logic [511:0] blk_in;
  logic         blk_load;
  logic [3:0]   req;
  logic [3:0]   gnt;
  logic [31:0]  data;
  logic         valid;
  logic [4:0]   words_left;
`ifdef RND_DISPATCH_STATS_EN
  logic [31:0]  grant_total;
`endif

  int checks = 0;
  int errors = 0;

  rnd_dispatch #(
    .NREQ (4)
  ) dut (
    .clk        (clk),
    .resn       (resn),
    .blk_in     (blk_in),
    .blk_load   (blk_load),
    .req        (req),
    .gnt        (gnt),
    .data       (data),
    .valid      (valid),
    .words_left (words_left)
`ifdef RND_DISPATCH_STATS_EN
    ,
    .grant_total(grant_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle record: expected outputs at this negedge, then req to drive.
  typedef struct {
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        valid;
    logic [31:0] data;
    logic [4:0]  left;
    logic        load;
  } vec_t;

  vec_t tv [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_blk(input logic [31:0] base);
    logic [511:0] b;
    for (int k = 0; k < 16; k++) begin
      b[32*k +: 32] = base + 32'(k);
    end
    return b;
  endfunction

  function automatic logic [31:0] w1(input int k);
    return 32'h1000_0000 + 32'(k);
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] last_g;
    int         since_load;
    int         win_valid;
    int         nloads;
    int         ngrants;
    logic       seen_load;

    //         req      gnt      v     data      left  load
    tv[0]  = '{4'b0100, 4'b0000, 1'b0, 32'h0,    5'd0,  1'b1};
    tv[1]  = '{4'b0000, 4'b0000, 1'b0, 32'h0,    5'd16, 1'b0};
    tv[2]  = '{4'b0100, 4'b0000, 1'b0, 32'h0,    5'd16, 1'b0};
    tv[3]  = '{4'b1111, 4'b0100, 1'b1, w1(0),    5'd15, 1'b0};
    tv[4]  = '{4'b1111, 4'b1000, 1'b1, w1(1),    5'd14, 1'b0};
    tv[5]  = '{4'b1111, 4'b0001, 1'b1, w1(2),    5'd13, 1'b0};
    tv[6]  = '{4'b1111, 4'b0010, 1'b1, w1(3),    5'd12, 1'b0};
    tv[7]  = '{4'b1111, 4'b0100, 1'b1, w1(4),    5'd11, 1'b0};
    tv[8]  = '{4'b0110, 4'b1000, 1'b1, w1(5),    5'd10, 1'b0};
    tv[9]  = '{4'b0110, 4'b0010, 1'b1, w1(6),    5'd9,  1'b0};
    tv[10] = '{4'b0110, 4'b0100, 1'b1, w1(7),    5'd8,  1'b0};
    tv[11] = '{4'b0000, 4'b0010, 1'b1, w1(8),    5'd7,  1'b0};
    tv[12] = '{4'b0001, 4'b0000, 1'b0, 32'h0,    5'd7,  1'b0};
    tv[13] = '{4'b0001, 4'b0001, 1'b1, w1(9),    5'd6,  1'b0};
    tv[14] = '{4'b1000, 4'b0001, 1'b1, w1(10),   5'd5,  1'b0};
    tv[15] = '{4'b0001, 4'b1000, 1'b1, w1(11),   5'd4,  1'b0};
    tv[16] = '{4'b0001, 4'b0001, 1'b1, w1(12),   5'd3,  1'b0};
    tv[17] = '{4'b0001, 4'b0001, 1'b1, w1(13),   5'd2,  1'b0};
    tv[18] = '{4'b0001, 4'b0001, 1'b1, w1(14),   5'd1,  1'b0};
    tv[19] = '{4'b0001, 4'b0001, 1'b1, w1(15),   5'd0,  1'b1};
    tv[20] = '{4'b0001, 4'b0000, 1'b0, 32'h0,    5'd16, 1'b0};
    tv[21] = '{4'b0001, 4'b0001, 1'b1, w1(0),    5'd15, 1'b0};
    tv[22] = '{4'b0000, 4'b0001, 1'b1, w1(1),    5'd14, 1'b0};
    tv[23] = '{4'b0000, 4'b0000, 1'b0, 32'h0,    5'd14, 1'b0};

    // Reset state
    resn   = 1'b0;
    req    = 4'b0000;
    blk_in = mk_blk(32'h1000_0000);
    repeat (3) @(negedge clk);
    chk("reset gnt",        32'(gnt),        32'h0);
    chk("reset valid",      32'(valid),      32'h0);
    chk("reset data",       data,            32'h0);
    chk("reset blk_load",   32'(blk_load),   32'h0);
    chk("reset words_left", 32'(words_left), 32'h0);

    // Release; the cycle up to the next edge is EMPTY, then LOAD.
    resn = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d gnt", i),   32'(gnt),        32'(tv[i].gnt));
      chk($sformatf("v%0d valid", i), 32'(valid),      32'(tv[i].valid));
      chk($sformatf("v%0d data", i),  data,            tv[i].data);
      chk($sformatf("v%0d left", i),  32'(words_left), 32'(tv[i].left));
      chk($sformatf("v%0d load", i),  32'(blk_load),   32'(tv[i].load));
      req = tv[i].req;
    end

    // Mid-block reset after 7 words of the current block.
    req = 4'b1111;
    repeat (5) @(negedge clk);
    chk("pre-reset left", 32'(words_left), 32'd9);
    #2;
    resn = 1'b0;
    #1;
    chk("async gnt",   32'(gnt),        32'h0);
    chk("async valid", 32'(valid),      32'h0);
    chk("async data",  data,            32'h0);
    chk("async left",  32'(words_left), 32'h0);
    chk("async load",  32'(blk_load),   32'h0);
    blk_in = mk_blk(32'h2000_0000);
    @(negedge clk);
    resn = 1'b1;
    @(negedge clk);
    chk("rst load pulse", 32'(blk_load), 32'h1);
    chk("rst load valid", 32'(valid),    32'h0);
    @(negedge clk);
    chk("rst serve left",  32'(words_left), 32'd16);
    chk("rst serve valid", 32'(valid),      32'h0);
    @(negedge clk);
    chk("rst first gnt",  32'(gnt),        32'h1);
    chk("rst first data", data,            32'h2000_0000);
    chk("rst first left", 32'(words_left), 32'd15);

    // Full demand: 16 valid words and one load per 17 cycles, strict rotation.
    last_g     = 4'b0001;
    since_load = 0;
    win_valid  = 0;
    nloads     = 0;
    seen_load  = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      chk($sformatf("fd%0d valid", c), 32'(valid), 32'(gnt != 4'b0000));
      if (gnt != 4'b0000) begin
        chk($sformatf("fd%0d rotate", c), 32'(gnt), 32'({last_g[2:0], last_g[3]}));
        last_g = gnt;
      end
      if (blk_load) begin
        if (seen_load) begin
          chk($sformatf("fd%0d period", c),  32'(since_load), 32'd17);
          chk($sformatf("fd%0d window", c),  32'(win_valid),  32'd16);
        end
        seen_load  = 1'b1;
        nloads++;
        since_load = 0;
        win_valid  = 0;
      end
      since_load++;
      if (valid) win_valid++;
    end
    checks++;
    if (nloads < 58 || nloads > 59) begin
      errors++;
      $display("FAIL fd load count: got %0d, expected 58 or 59", nloads);
    end

    // Forty grants from a fresh reset.
    req  = 4'b0000;
    resn = 1'b0;
    @(negedge clk);
`ifdef RND_DISPATCH_STATS_EN
    chk("stats after reset", grant_total, 32'd0);
`endif
    resn    = 1'b1;
    req     = 4'b1111;
    ngrants = 0;
    for (int c = 0; c < 200 && ngrants < 40; c++) begin
      @(negedge clk);
      if (valid) ngrants++;
      if (ngrants == 40) req = 4'b0000;
    end
    chk("forty grants reached", 32'(ngrants), 32'd40);
    @(negedge clk);
    chk("forty idle valid", 32'(valid),      32'h0);
    chk("forty left",       32'(words_left), 32'd8);
`ifdef RND_DISPATCH_STATS_EN
    chk("stats forty", grant_total, 32'd40);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
